// File: rtl/vdot_serial_ctrl_pkg.sv
// Shared definitions for the sequenced half-precision dot-product engine:
// FSM encoding, lane geometry and FP16 constants.
package vdot_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int LANE_W    = 16;
    localparam int DEF_LANES = 16;

    localparam logic [15:0] FP16_ONE     = 16'h3C00;
    localparam logic [15:0] FP16_TWO     = 16'h4000;
    localparam logic [15:0] FP16_MAXH    = 16'h7BFF;
    localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

    // Leading-zero count of a 14-bit value measured from bit 13 (14 when zero).
    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] n;
        n = 4'd14;
        for (int i = 0; i <= 13; i++) begin
            if (v[i]) n = 4'(13 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/vdot_serial_ctrl_fpcores.sv
// Single-lane FP16 cores shared with the vector unit: VMULT and VADD.
// Subnormals flush to zero, rounding is round-to-nearest-even, and any result
// beyond the largest finite value (or an Inf/NaN input) gives +/-Inf with o_ov.
module vmult
    import vdot_serial_ctrl_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_p,
    output logic        o_ov
);

    logic        w_sign;
    logic [21:0] w_prod;
    logic [20:0] w_norm;
    logic [6:0]  w_esum;
    logic        w_up;
    logic [16:0] w_rnd;

    // Significand product, normalise, round, then classify the exponent.
    always_comb begin
        w_sign = i_a[15] ^ i_b[15];
        w_prod = {11'd0, 1'b1, i_a[9:0]} * {11'd0, 1'b1, i_b[9:0]};
        w_norm = w_prod[21] ? w_prod[20:0] : {w_prod[19:0], 1'b0};
        w_esum = {2'b00, i_a[14:10]} + {2'b00, i_b[14:10]} + {6'd0, w_prod[21]};
        w_up   = w_norm[10] & ((|w_norm[9:0]) | w_norm[11]);
        w_rnd  = {w_esum, w_norm[20:11]} - {7'd15, 10'd0} + {16'd0, w_up};
        o_p    = {w_sign, w_rnd[14:0]};
        o_ov   = 1'b0;
        if (i_a[14:10] == 5'h1F || i_b[14:10] == 5'h1F) begin
            o_p  = {w_sign, FP16_INF_MAG};
            o_ov = 1'b1;
        end else if (i_a[14:10] == 5'd0 || i_b[14:10] == 5'd0 || w_esum <= 7'd15) begin
            o_p = {w_sign, 15'd0};
        end else if (w_rnd[16:10] >= 7'd31) begin
            o_p  = {w_sign, FP16_INF_MAG};
            o_ov = 1'b1;
        end
    end

endmodule

module vadd
    import vdot_serial_ctrl_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_s,
    output logic        o_ov
);

    logic              w_swap;
    logic [15:0]       w_big;
    logic [15:0]       w_sml;
    logic [10:0]       w_sb;
    logic [10:0]       w_ss;
    logic [4:0]        w_shift;
    logic [23:0]       w_full;
    logic [13:0]       w_al;
    logic [14:0]       w_sum;
    logic [3:0]        w_lz;
    logic [13:0]       w_n;
    logic signed [7:0] w_e;
    logic              w_up;
    logic [16:0]       w_rnd;

    // Order by magnitude, align with guard/round/sticky, add or subtract,
    // renormalise and round.
    always_comb begin
        w_swap  = i_b[14:0] > i_a[14:0];
        w_big   = w_swap ? i_b : i_a;
        w_sml   = w_swap ? i_a : i_b;
        w_sb    = (w_big[14:10] != 5'd0) ? {1'b1, w_big[9:0]} : 11'd0;
        w_ss    = (w_sml[14:10] != 5'd0) ? {1'b1, w_sml[9:0]} : 11'd0;
        w_shift = w_big[14:10] - w_sml[14:10];
        w_full  = {w_ss, 13'd0} >> w_shift;
        w_al    = {w_full[23:11], |w_full[10:0]};
        if (w_big[15] == w_sml[15]) begin
            w_sum = {1'b0, w_sb, 3'b000} + {1'b0, w_al};
        end else begin
            w_sum = {1'b0, w_sb, 3'b000} - {1'b0, w_al};
        end
        w_lz = lzc14(w_sum[13:0]);
        if (w_sum[14]) begin
            w_n = {w_sum[14:2], w_sum[1] | w_sum[0]};
            w_e = $signed({3'b000, w_big[14:10]}) + 8'sd1;
        end else begin
            w_n = w_sum[13:0] << w_lz;
            w_e = $signed({3'b000, w_big[14:10]}) - $signed({4'b0000, w_lz});
        end
        w_up  = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        w_rnd = {w_e[6:0], w_n[12:3]} + {16'd0, w_up};
        o_s   = {w_big[15], w_rnd[14:0]};
        o_ov  = 1'b0;
        if (i_a[14:10] == 5'h1F || i_b[14:10] == 5'h1F) begin
            o_s  = {w_big[15], FP16_INF_MAG};
            o_ov = 1'b1;
        end else if (!w_n[13] || w_e <= 8'sd0) begin
            o_s = 16'd0;
        end else if (w_rnd[16:10] >= 7'd31) begin
            o_s  = {w_big[15], FP16_INF_MAG};
            o_ov = 1'b1;
        end
    end

endmodule

// File: rtl/vdot_serial_ctrl_lane_mux.sv
// vdot_lane_mux: picks lane i_idx out of the two latched operand vectors.
module vdot_lane_mux
    import vdot_serial_ctrl_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int W     = LANE_W,
    parameter int IDXW  = $clog2(LANES)
) (
    input  logic [LANES*W-1:0] i_a,
    input  logic [LANES*W-1:0] i_b,
    input  logic [IDXW-1:0]    i_idx,
    output logic [W-1:0]       o_a,
    output logic [W-1:0]       o_b
);

    logic [W-1:0] w_lane_a [LANES];
    logic [W-1:0] w_lane_b [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lane_a[gi] = i_a[gi*W +: W];
            assign w_lane_b[gi] = i_b[gi*W +: W];
        end
    endgenerate

    assign o_a = w_lane_a[i_idx];
    assign o_b = w_lane_b[i_idx];

endmodule

// File: rtl/vdot_serial_ctrl.sv
// vdot_serial_ctrl: multi-cycle FP16 dot product. Latches A/B on start, walks
// one VMULT and one VADD across the lanes, accumulating ((p0+p1)+p2)+... with a
// sticky overflow flag. Optional macro VDOT_EARLY_OV_EN: once overflow is seen
// the remaining lanes are skipped and the operation completes early.
module vdot_serial_ctrl
    import vdot_serial_ctrl_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int W     = LANE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LANES*W-1:0] A,
    input  logic [LANES*W-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [W-1:0]       out,
    output logic               V
);

    localparam int IDXW = $clog2(LANES);

    state_t             r_state;
    state_t             w_state_next;
    logic [LANES*W-1:0] r_a;
    logic [LANES*W-1:0] r_b;
    logic [IDXW-1:0]    r_idx;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_preg;
    logic [W-1:0]       r_out;
    logic               r_pvalid;
    logic               r_ovacc;
    logic               r_v;
    logic               r_done;

    logic [W-1:0]       w_lane_a;
    logic [W-1:0]       w_lane_b;
    logic [W-1:0]       w_prod;
    logic [W-1:0]       w_sum;
    logic               w_mul_ov;
    logic               w_add_ov;
    logic               w_last;
    logic               w_first;
    logic               w_exit;

    vdot_lane_mux #(.LANES(LANES), .W(W), .IDXW(IDXW)) u_lane_mux (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_idx (r_idx),
        .o_a   (w_lane_a),
        .o_b   (w_lane_b)
    );

    vmult u_vmult (
        .i_a  (w_lane_a),
        .i_b  (w_lane_b),
        .o_p  (w_prod),
        .o_ov (w_mul_ov)
    );

    vadd u_vadd (
        .i_a  (r_acc),
        .i_b  (r_preg),
        .o_s  (w_sum),
        .o_ov (w_add_ov)
    );

    // The product pipeline is one lane behind idx, so the first accumulate
    // (a plain load of p0) happens when idx has already reached 1.
    assign w_last  = (r_idx == IDXW'(LANES - 1));
    assign w_first = (r_idx == IDXW'(1));

`ifdef VDOT_EARLY_OV_EN
    assign w_exit = w_last | r_ovacc;
`else
    assign w_exit = w_last;
`endif

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign out  = r_out;
    assign V    = r_v;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_RUN;
            ST_RUN:   if (w_exit) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, multiply/accumulate stepping, result update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_preg   <= '0;
            r_out    <= '0;
            r_pvalid <= 1'b0;
            r_ovacc  <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_idx    <= '0;
                        r_pvalid <= 1'b0;
                        r_ovacc  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_preg   <= w_prod;
                    r_pvalid <= 1'b1;
                    if (r_pvalid) begin
                        r_acc <= w_first ? r_preg : w_sum;
                    end
                    r_ovacc <= r_ovacc | w_mul_ov | (r_pvalid & ~w_first & w_add_ov);
                    if (!w_last) begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_DRAIN: begin
                    r_acc  <= w_sum;
                    r_out  <= w_sum;
                    r_v    <= r_ovacc | w_add_ov;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
